// File: rtl/common_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package common_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    localparam int unsigned DIV_ITERATIONS = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q  = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_iter (
    input  logic [31:0] rem,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // rem < divisor, so a non-negative difference always fits in 32 bits and bit 32 is the borrow
    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[32];
        rem_next = q_bit ? diff[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M multiply/divide sequencer with request/result handshakes and pipeline stall.
module muldiv_ctrl
    import common_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  muldiv_op_t      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            stall
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_EXEC,
        DIV_EXEC,
        DIV_FIX,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    muldiv_op_t      op_q;
    logic [XLEN-1:0] opa_q;
    logic [XLEN-1:0] opb_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] res_q;
    logic [4:0]      cnt_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic            accept;
    logic            req_div;
    logic            req_sdiv;
    logic            b_zero;
    logic            sdiv_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    logic            mul_sa;
    logic            mul_sb;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic [63:0]     prod;
    logic [XLEN-1:0] mul_res;

    logic [XLEN-1:0] iter_rem;
    logic            iter_qbit;
    logic [XLEN-1:0] fix_res;

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);
    assign res_valid = (state == DONE);
    assign res_data  = res_q;
    assign accept    = req_valid && req_ready && !flush;

    always_comb begin
        req_div     = op_is_div(req_op);
        req_sdiv    = (req_op == DIV) || (req_op == REM);
        b_zero      = (req_b == '0);
        sdiv_ovf    = req_sdiv && (req_a == 32'h8000_0000) && (req_b == '1);
        special     = req_div && (b_zero || sdiv_ovf);
        abs_a       = (req_sdiv && req_a[XLEN-1]) ? -req_a : req_a;
        abs_b       = (req_sdiv && req_b[XLEN-1]) ? -req_b : req_b;
        special_res = '0;
        if (b_zero) begin
            special_res = ((req_op == DIV) || (req_op == DIVU)) ? DIV_BY_ZERO_Q : req_a;
        end else if (req_op == DIV) begin
            special_res = 32'h8000_0000;
        end
    end

    // Operands are sign/zero-extended to 33 bits; only the low 64 product bits are ever returned
    always_comb begin
        mul_sa  = (op_q == MUL) || (op_q == MULH) || (op_q == MULHSU);
        mul_sb  = (op_q == MUL) || (op_q == MULH);
        mul_a   = 64'($signed({mul_sa & opa_q[XLEN-1], opa_q}));
        mul_b   = 64'($signed({mul_sb & opb_q[XLEN-1], opb_q}));
        prod    = mul_a * mul_b;
        mul_res = (op_q == MUL) ? prod[31:0] : prod[63:32];
    end

    div_iter u_div_iter (
        .rem          (rem_q),
        .dividend_bit (opa_q[XLEN-1]),
        .divisor      (opb_q),
        .rem_next     (iter_rem),
        .q_bit        (iter_qbit)
    );

    always_comb begin
        if ((op_q == DIV) || (op_q == DIVU)) begin
            fix_res = q_neg_q ? -opa_q : opa_q;
        end else begin
            fix_res = r_neg_q ? -rem_q : rem_q;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_div)     state_next = MUL_EXEC;
                        else if (special) state_next = DONE;
                        else              state_next = DIV_EXEC;
                    end
                end
                MUL_EXEC: state_next = DONE;
                DIV_EXEC: if (cnt_q == '0) state_next = DIV_FIX;
                DIV_FIX:  state_next = DONE;
                DONE:     if (res_ready) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // During DIV_EXEC opa_q doubles as the dividend/quotient shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= MUL;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        if (req_div) begin
                            opa_q   <= abs_a;
                            opb_q   <= abs_b;
                            rem_q   <= '0;
                            cnt_q   <= 5'(DIV_ITERATIONS - 1);
                            q_neg_q <= req_sdiv && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                            r_neg_q <= req_sdiv && req_a[XLEN-1];
                            if (special) res_q <= special_res;
                        end else begin
                            opa_q <= req_a;
                            opb_q <= req_b;
                        end
                    end
                end
                MUL_EXEC: res_q <= mul_res;
                DIV_EXEC: begin
                    rem_q <= iter_rem;
                    opa_q <= {opa_q[XLEN-2:0], iter_qbit};
                    if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
                end
                DIV_FIX: res_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model plus directed literal cases.
module tb_muldiv_ctrl;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    muldiv_op_t  req_op = MUL;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        stall;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .stall     (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_sovf(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        return ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (op)
            MUL:    begin p = 64'(sa * sb); r = p[31:0];  end
            MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
            MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
            MULHU:  begin p = 64'(ua * ub); r = p[63:32]; end
            DIV:    r = (b == 0) ? 32'hFFFF_FFFF : is_sovf(op, a, b) ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            REM:    r = (b == 0) ? a : is_sovf(op, a, b) ? 32'h0 : 32'($signed(a) % $signed(b));
            DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU:   r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        if (!(op inside {DIV, DIVU, REM, REMU})) return 2;
        if (b == 0 || is_sovf(op, a, b)) return 1;
        return 34;
    endfunction

    // Reference model: busy/done flags plus a countdown to result availability
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_res  <= ref_result(req_op, req_a, req_b);
                m_left <= lat_of(req_op, req_a, req_b) - 1;
                m_done <= (lat_of(req_op, req_a, req_b) == 1);
            end
        end else if (m_done) begin
            if (res_ready) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end else begin
            if (m_left == 1) m_done <= 1'b1;
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("stall", 32'(stall), 32'(m_busy));
            check("res_valid", 32'(res_valid), 32'(m_done));
            if (m_done) check("res_data", res_data, m_res);
        end
    end

    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; res_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
        cyc = 1;
        while (!res_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check(name, res_data, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cnt;
        int cyc;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset stall", 32'(stall), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_data", res_data, 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul");
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh");
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div");
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem");
        run_op(DIVU,   32'd100,       32'd7,         32'd14,        34, "divu");
        run_op(REMU,   32'd100,       32'd7,         32'd2,         34, "remu");
        run_op(DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1, "divu by zero");
        run_op(REM,    32'd100,       32'd0,         32'd100,       1, "rem by zero");
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div overflow");
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem overflow");

        // Flush during iteration 10 of a divide
        @(negedge clk);
        req_valid = 1'b1; req_op = DIV; req_a = 32'd1000; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush req_ready", 32'(req_ready), 32'd1);
        check("flush stall", 32'(stall), 32'd0);
        check("flush res_valid", 32'(res_valid), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        check("flush no result", 32'(cnt), 32'd0);
        run_op(MUL, 32'd3, 32'd5, 32'd15, 2, "mul after flush");

        // Request presented together with flush is ignored
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL; req_a = 32'd9; req_b = 32'd9; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept", 32'(stall), 32'd0);

        // Backpressure on a divide result
        @(negedge clk);
        req_valid = 1'b1; req_op = DIVU; req_a = 32'd100; req_b = 32'd7; res_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", 32'(cyc), 32'd34);
        repeat (5) begin
            @(negedge clk);
            check("bp res_valid", 32'(res_valid), 32'd1);
            check("bp res_data", res_data, 32'd14);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp stall", 32'(stall), 32'd1);
        end
        res_ready = 1'b1;
        run_op(MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 2, "mul after bp");

        // Reset asserted mid-divide
        @(negedge clk);
        req_valid = 1'b1; req_op = DIV; req_a = 32'd12345; req_b = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset req_ready", 32'(req_ready), 32'd1);
        check("midreset stall", 32'(stall), 32'd0);
        check("midreset res_valid", 32'(res_valid), 32'd0);
        check("midreset res_data", res_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        check("no result after reset", 32'(cnt), 32'd0);

        // Randomized traffic with backpressure and occasional flush
        repeat (3000) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = muldiv_op_t'($urandom_range(0, 7));
            req_a     = pick();
            req_b     = pick();
            res_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 2);
        end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
